// File: rtl/cv32e40x_rvfi_mem_tracker.sv
// RVFI data-memory tracker: groups OBI data transactions per instruction in a
// two-deep ping-pong buffer and releases them to RVFI when WB retires.
// Optional: define CV32E40X_RVFI_MEM_ERR_EN to add bus-error reporting ports.
module cv32e40x_rvfi_mem_tracker #(
  parameter int NMEM = 16,
  parameter int NBUF = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           lsu_req_valid_i,
  output logic                           lsu_req_ready_o,
  input  logic                           lsu_req_last_i,
  input  logic                           lsu_req_we_i,
  input  logic [3:0]                     lsu_req_be_i,
  input  logic [31:0]                    lsu_req_addr_i,
  input  logic [31:0]                    lsu_req_wdata_i,
  input  logic                           lsu_resp_valid_i,
  input  logic [31:0]                    lsu_resp_rdata_i,
  input  logic                           lsu_resp_err_i,
  input  logic                           wb_mem_i,
  input  logic                           wb_retire_i,
  output logic                           mem_done_o,
  output logic                           rvfi_mem_valid_o,
  output logic [$clog2(NMEM+1)-1:0]      rvfi_mem_cnt_o,
  output logic [NMEM*32-1:0]             rvfi_mem_addr_o,
  output logic [NMEM*4-1:0]              rvfi_mem_rmask_o,
  output logic [NMEM*4-1:0]              rvfi_mem_wmask_o,
  output logic [NMEM*32-1:0]             rvfi_mem_rdata_o,
  output logic [NMEM*32-1:0]             rvfi_mem_wdata_o,
  output logic                           rvfi_mem_ovf_o
`ifdef CV32E40X_RVFI_MEM_ERR_EN
  ,
  output logic [1:0]                     rvfi_mem_err_o,
  output logic                           rvfi_mem_err_valid_o
`endif
);

  // Request/response counters are wider than a slot index so dropped
  // (overflowed) requests still pair up with their responses.
  localparam int CW = 8;
  localparam int SW = $clog2(NMEM);
  localparam int NW = $clog2(NMEM+1);
  localparam logic [CW-1:0] NMEM_C = CW'(NMEM);
  localparam logic [NW-1:0] NMEM_N = NW'(NMEM);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_WAIT_RESP, ST_COMPLETE} buf_state_e;

`ifdef CV32E40X_RVFI_MEM_ERR_EN
  typedef enum logic [1:0] {MEM_ERR_NONE = 2'd0, MEM_ERR_PMP = 2'd1} mem_err_t;
  logic          err_q [NBUF];
  logic          err_d [NBUF];
  logic [SW-1:0] err_slot_q [NBUF];
  mem_err_t      err_code_q;
  logic          err_valid_q;
`else
  logic unused_resp_err;
  assign unused_resp_err = lsu_resp_err_i;
`endif

  buf_state_e    state_q [NBUF];
  buf_state_e    state_d [NBUF];
  logic [CW-1:0] req_cnt_q [NBUF];
  logic [CW-1:0] req_cnt_d [NBUF];
  logic [CW-1:0] resp_cnt_q [NBUF];
  logic [CW-1:0] resp_cnt_d [NBUF];
  logic          grp_ovf_q [NBUF];
  logic          grp_ovf_d [NBUF];
  logic          fill_ptr_q, fill_ptr_d;
  logic          resp_ptr_q, resp_ptr_d;
  logic          ret_ptr_q, ret_ptr_d;
  logic          mem_done_q;

  logic [31:0]   addr_q  [NBUF][NMEM];
  logic [31:0]   wdata_q [NBUF][NMEM];
  logic [31:0]   rdata_q [NBUF][NMEM];
  logic [3:0]    rmask_q [NBUF][NMEM];
  logic [3:0]    wmask_q [NBUF][NMEM];

  logic                rvfi_valid_q, rvfi_ovf_q;
  logic [NW-1:0]       rvfi_cnt_q;
  logic [NMEM*32-1:0]  rvfi_addr_q, rvfi_rdata_q, rvfi_wdata_q;
  logic [NMEM*4-1:0]   rvfi_rmask_q, rvfi_wmask_q;

  logic          req_fire, req_store, resp_fire, resp_final, ret_mem;
  logic [CW-1:0] req_slot, resp_slot;
  logic [NW-1:0] ret_cnt;

  // Ready depends only on registered state, so a retire frees space next cycle.
  assign lsu_req_ready_o = (state_q[fill_ptr_q] == ST_EMPTY) || (state_q[fill_ptr_q] == ST_FILLING);
  assign req_fire   = lsu_req_valid_i & lsu_req_ready_o;
  assign req_slot   = (state_q[fill_ptr_q] == ST_EMPTY) ? '0 : req_cnt_q[fill_ptr_q];
  assign req_store  = req_fire && (req_slot < NMEM_C);
  assign resp_fire  = lsu_resp_valid_i;
  assign resp_slot  = resp_cnt_q[resp_ptr_q];
  // Final response: every issued request of a closed group has answered.
  assign resp_final = resp_fire && (state_q[resp_ptr_q] != ST_FILLING) &&
                      ((resp_slot + CW'(1)) == req_cnt_q[resp_ptr_q]);
  assign ret_mem    = wb_retire_i & wb_mem_i;
  assign ret_cnt    = (req_cnt_q[ret_ptr_q] > NMEM_C) ? NMEM_N : req_cnt_q[ret_ptr_q][NW-1:0];

  // Next-state for per-buffer FSMs, counters and the three ring pointers.
  always_comb begin
    for (int b = 0; b < NBUF; b++) begin
      state_d[b]    = state_q[b];
      req_cnt_d[b]  = req_cnt_q[b];
      resp_cnt_d[b] = resp_cnt_q[b];
      grp_ovf_d[b]  = grp_ovf_q[b];
`ifdef CV32E40X_RVFI_MEM_ERR_EN
      err_d[b]      = err_q[b];
`endif
    end
    fill_ptr_d = fill_ptr_q;
    resp_ptr_d = resp_ptr_q;
    ret_ptr_d  = ret_ptr_q;
    if (req_fire) begin
      req_cnt_d[fill_ptr_q] = req_slot + CW'(1);
      if (state_q[fill_ptr_q] == ST_EMPTY) begin
        resp_cnt_d[fill_ptr_q] = '0;
        grp_ovf_d[fill_ptr_q]  = 1'b0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        err_d[fill_ptr_q]      = 1'b0;
`endif
      end
      if (!req_store) grp_ovf_d[fill_ptr_q] = 1'b1;
      if (lsu_req_last_i) begin
        state_d[fill_ptr_q] = ST_WAIT_RESP;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        if (err_q[fill_ptr_q]) state_d[fill_ptr_q] = ST_COMPLETE;
`endif
        fill_ptr_d = ~fill_ptr_q;
      end else begin
        state_d[fill_ptr_q] = ST_FILLING;
      end
    end
    if (resp_fire) begin
      resp_cnt_d[resp_ptr_q] = resp_slot + CW'(1);
      if (resp_final) begin
        resp_ptr_d = ~resp_ptr_q;
        if (state_q[resp_ptr_q] == ST_WAIT_RESP) state_d[resp_ptr_q] = ST_COMPLETE;
      end
`ifdef CV32E40X_RVFI_MEM_ERR_EN
      if (lsu_resp_err_i && !err_q[resp_ptr_q]) begin
        err_d[resp_ptr_q] = 1'b1;
        if (state_q[resp_ptr_q] == ST_WAIT_RESP) state_d[resp_ptr_q] = ST_COMPLETE;
      end
`endif
    end
    if (ret_mem) begin
      state_d[ret_ptr_q] = ST_EMPTY;
      ret_ptr_d          = ~ret_ptr_q;
    end
  end

  // Control state registers; mem_done is registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBUF; b++) begin
        state_q[b]    <= ST_EMPTY;
        req_cnt_q[b]  <= '0;
        resp_cnt_q[b] <= '0;
        grp_ovf_q[b]  <= 1'b0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        err_q[b]      <= 1'b0;
`endif
      end
      fill_ptr_q <= 1'b0;
      resp_ptr_q <= 1'b0;
      ret_ptr_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      for (int b = 0; b < NBUF; b++) begin
        state_q[b]    <= state_d[b];
        req_cnt_q[b]  <= req_cnt_d[b];
        resp_cnt_q[b] <= resp_cnt_d[b];
        grp_ovf_q[b]  <= grp_ovf_d[b];
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        err_q[b]      <= err_d[b];
`endif
      end
      fill_ptr_q <= fill_ptr_d;
      resp_ptr_q <= resp_ptr_d;
      ret_ptr_q  <= ret_ptr_d;
      mem_done_q <= (state_d[ret_ptr_d] == ST_COMPLETE);
    end
  end

  // Slot storage; stale slots are hidden at retire by masking with cnt.
  always_ff @(posedge clk) begin
    if (req_store) begin
      addr_q[fill_ptr_q][req_slot[SW-1:0]]  <= lsu_req_addr_i;
      wdata_q[fill_ptr_q][req_slot[SW-1:0]] <= lsu_req_wdata_i;
      rdata_q[fill_ptr_q][req_slot[SW-1:0]] <= '0;
      rmask_q[fill_ptr_q][req_slot[SW-1:0]] <= lsu_req_we_i ? 4'h0 : lsu_req_be_i;
      wmask_q[fill_ptr_q][req_slot[SW-1:0]] <= lsu_req_we_i ? lsu_req_be_i : 4'h0;
    end
    if (resp_fire && (resp_slot < NMEM_C) && (rmask_q[resp_ptr_q][resp_slot[SW-1:0]] != 4'h0)
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        && !err_q[resp_ptr_q]
`endif
       ) begin
      rdata_q[resp_ptr_q][resp_slot[SW-1:0]] <= lsu_resp_rdata_i;
    end
`ifdef CV32E40X_RVFI_MEM_ERR_EN
    if (resp_fire && lsu_resp_err_i && !err_q[resp_ptr_q]) begin
      err_slot_q[resp_ptr_q] <= resp_slot[SW-1:0];
    end
`endif
  end

  // RVFI output registers: one-cycle pulse per retire, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvfi_valid_q <= 1'b0;
      rvfi_cnt_q   <= '0;
      rvfi_ovf_q   <= 1'b0;
      rvfi_addr_q  <= '0;
      rvfi_rdata_q <= '0;
      rvfi_wdata_q <= '0;
      rvfi_rmask_q <= '0;
      rvfi_wmask_q <= '0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
      err_code_q   <= MEM_ERR_NONE;
      err_valid_q  <= 1'b0;
`endif
    end else begin
      rvfi_valid_q <= wb_retire_i;
      rvfi_cnt_q   <= '0;
      rvfi_ovf_q   <= 1'b0;
      rvfi_addr_q  <= '0;
      rvfi_rdata_q <= '0;
      rvfi_wdata_q <= '0;
      rvfi_rmask_q <= '0;
      rvfi_wmask_q <= '0;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
      err_code_q   <= MEM_ERR_NONE;
      err_valid_q  <= 1'b0;
`endif
      if (ret_mem) begin
        rvfi_cnt_q <= ret_cnt;
        rvfi_ovf_q <= grp_ovf_q[ret_ptr_q];
        for (int s = 0; s < NMEM; s++) begin
          if (s < int'(ret_cnt)) begin
            rvfi_addr_q[s*32 +: 32]  <= addr_q[ret_ptr_q][s];
            rvfi_rdata_q[s*32 +: 32] <= rdata_q[ret_ptr_q][s];
            rvfi_wdata_q[s*32 +: 32] <= wdata_q[ret_ptr_q][s];
            rvfi_rmask_q[s*4 +: 4]   <= rmask_q[ret_ptr_q][s];
            rvfi_wmask_q[s*4 +: 4]   <= wmask_q[ret_ptr_q][s];
          end
        end
`ifdef CV32E40X_RVFI_MEM_ERR_EN
        err_code_q  <= err_q[ret_ptr_q] ? MEM_ERR_PMP : MEM_ERR_NONE;
        err_valid_q <= err_q[ret_ptr_q];
`endif
      end
    end
  end

  assign mem_done_o       = mem_done_q;
  assign rvfi_mem_valid_o = rvfi_valid_q;
  assign rvfi_mem_cnt_o   = rvfi_cnt_q;
  assign rvfi_mem_ovf_o   = rvfi_ovf_q;
  assign rvfi_mem_addr_o  = rvfi_addr_q;
  assign rvfi_mem_rdata_o = rvfi_rdata_q;
  assign rvfi_mem_wdata_o = rvfi_wdata_q;
  assign rvfi_mem_rmask_o = rvfi_rmask_q;
  assign rvfi_mem_wmask_o = rvfi_wmask_q;
`ifdef CV32E40X_RVFI_MEM_ERR_EN
  assign rvfi_mem_err_o       = err_code_q;
  assign rvfi_mem_err_valid_o = err_valid_q;
`endif

`ifndef SYNTHESIS
  // Protocol guards on the LSU and controller side.
  a_req_when_ready: assert property (@(posedge clk) disable iff (!rst_n)
    lsu_req_valid_i |-> lsu_req_ready_o);
  a_retire_when_done: assert property (@(posedge clk) disable iff (!rst_n)
    (wb_retire_i && wb_mem_i) |-> mem_done_o);
`endif

endmodule

// File: tb/tb_cv32e40x_rvfi_mem_tracker.sv
// Directed bench for cv32e40x_rvfi_mem_tracker with a retire-order scoreboard.
module tb_cv32e40x_rvfi_mem_tracker;
  localparam int NMEM = 16;
  localparam int NW   = $clog2(NMEM+1);

  logic clk = 1'b0;
  logic rst_n;
  logic lsu_req_valid_i, lsu_req_ready_o, lsu_req_last_i, lsu_req_we_i;
  logic [3:0]  lsu_req_be_i;
  logic [31:0] lsu_req_addr_i, lsu_req_wdata_i, lsu_resp_rdata_i;
  logic lsu_resp_valid_i, lsu_resp_err_i, wb_mem_i, wb_retire_i;
  logic mem_done_o, rvfi_mem_valid_o, rvfi_mem_ovf_o;
  logic [NW-1:0]      rvfi_mem_cnt_o;
  logic [NMEM*32-1:0] rvfi_mem_addr_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o;
  logic [NMEM*4-1:0]  rvfi_mem_rmask_o, rvfi_mem_wmask_o;

  cv32e40x_rvfi_mem_tracker #(.NMEM(NMEM), .NBUF(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_req_last_i(lsu_req_last_i), .lsu_req_we_i(lsu_req_we_i),
    .lsu_req_be_i(lsu_req_be_i), .lsu_req_addr_i(lsu_req_addr_i),
    .lsu_req_wdata_i(lsu_req_wdata_i), .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_rdata_i(lsu_resp_rdata_i), .lsu_resp_err_i(lsu_resp_err_i),
    .wb_mem_i(wb_mem_i), .wb_retire_i(wb_retire_i), .mem_done_o(mem_done_o),
    .rvfi_mem_valid_o(rvfi_mem_valid_o), .rvfi_mem_cnt_o(rvfi_mem_cnt_o),
    .rvfi_mem_addr_o(rvfi_mem_addr_o), .rvfi_mem_rmask_o(rvfi_mem_rmask_o),
    .rvfi_mem_wmask_o(rvfi_mem_wmask_o), .rvfi_mem_rdata_o(rvfi_mem_rdata_o),
    .rvfi_mem_wdata_o(rvfi_mem_wdata_o), .rvfi_mem_ovf_o(rvfi_mem_ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0]      cnt;
    logic               ovf;
    logic [NMEM*32-1:0] addr, rdata, wdata;
    logic [NMEM*4-1:0]  rmask, wmask;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur, mon_e;
  int n_checks = 0;
  int n_err = 0;
  int n_pulses = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic exp_new(input int cnt, input bit ovf);
    cur.cnt = NW'(cnt); cur.ovf = ovf;
    cur.addr = '0; cur.rdata = '0; cur.wdata = '0; cur.rmask = '0; cur.wmask = '0;
  endtask

  task automatic exp_slot(input int s, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] rd, input logic [31:0] wd);
    cur.addr[s*32 +: 32] = a;  cur.rdata[s*32 +: 32] = rd; cur.wdata[s*32 +: 32] = wd;
    cur.rmask[s*4 +: 4]  = rm; cur.wmask[s*4 +: 4]  = wm;
  endtask

  // Monitor: every RVFI pulse is compared against the oldest expected group.
  always @(negedge clk) begin
    if (rst_n && rvfi_mem_valid_o) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL unexpected_pulse: got pulse cnt=%0d expected none", rvfi_mem_cnt_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("rvfi_cnt",   512'(rvfi_mem_cnt_o),   512'(mon_e.cnt));
        check("rvfi_ovf",   512'(rvfi_mem_ovf_o),   512'(mon_e.ovf));
        check("rvfi_addr",  512'(rvfi_mem_addr_o),  512'(mon_e.addr));
        check("rvfi_rmask", 512'(rvfi_mem_rmask_o), 512'(mon_e.rmask));
        check("rvfi_wmask", 512'(rvfi_mem_wmask_o), 512'(mon_e.wmask));
        check("rvfi_rdata", 512'(rvfi_mem_rdata_o), 512'(mon_e.rdata));
        check("rvfi_wdata", 512'(rvfi_mem_wdata_o), 512'(mon_e.wdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input bit we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input bit last);
    int k = 0;
    while (!lsu_req_ready_o && k < 50) begin tick(); k++; end
    if (!lsu_req_ready_o) begin
      n_checks++; n_err++;
      $display("FAIL req_ready_timeout: ready=0 expected 1");
      return;
    end
    lsu_req_valid_i = 1'b1; lsu_req_we_i = we; lsu_req_be_i = be;
    lsu_req_addr_i = a; lsu_req_wdata_i = wd; lsu_req_last_i = last;
    tick();
    lsu_req_valid_i = 1'b0; lsu_req_last_i = 1'b0;
  endtask

  task automatic do_resp(input logic [31:0] d, input bit final_chk);
    lsu_resp_valid_i = 1'b1; lsu_resp_rdata_i = d;
    if (final_chk) check("done_low_in_final_resp_cycle", 512'(mem_done_o), 512'(0));
    tick();
    lsu_resp_valid_i = 1'b0;
    if (final_chk) check("done_high_after_final_resp", 512'(mem_done_o), 512'(1));
  endtask

  task automatic do_retire(input bit mem);
    int k = 0;
    if (mem) begin
      while (!mem_done_o && k < 50) begin tick(); k++; end
      if (!mem_done_o) begin
        n_checks++; n_err++;
        $display("FAIL retire_done_timeout: mem_done=0 expected 1");
        return;
      end
    end
    wb_retire_i = 1'b1; wb_mem_i = mem;
    tick();
    wb_retire_i = 1'b0; wb_mem_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    lsu_req_valid_i = 0; lsu_req_last_i = 0; lsu_req_we_i = 0; lsu_req_be_i = 0;
    lsu_req_addr_i = 0; lsu_req_wdata_i = 0; lsu_resp_valid_i = 0; lsu_resp_rdata_i = 0;
    lsu_resp_err_i = 0; wb_mem_i = 0; wb_retire_i = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_ready",    512'(lsu_req_ready_o),  512'(1));
    check("reset_done",     512'(mem_done_o),       512'(0));
    check("reset_valid",    512'(rvfi_mem_valid_o), 512'(0));
    check("reset_cnt",      512'(rvfi_mem_cnt_o),   512'(0));
    check("reset_addr",     512'(rvfi_mem_addr_o),  512'(0));

    // Single load
    do_req(1'b0, 4'hF, 32'h100, 32'h0, 1'b1);
    check("load_done_before_resp", 512'(mem_done_o), 512'(0));
    do_resp(32'hDEADBEEF, 1'b1);
    exp_new(1, 1'b0); exp_slot(0, 32'h100, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0);
    exp_q.push_back(cur);
    do_retire(1'b1);
    check("load_done_after_retire", 512'(mem_done_o), 512'(0));

    // Push of five words, responses carry junk that must not be recorded
    for (int i = 0; i < 5; i++) do_req(1'b1, 4'hF, 32'h200 - 32'(4*i), 32'h1000 + 32'(i), i == 4);
    for (int i = 0; i < 4; i++) do_resp(32'hBAD00000 + 32'(i), 1'b0);
    check("push_done_before_last_resp", 512'(mem_done_o), 512'(0));
    do_resp(32'hBAD00004, 1'b1);
    exp_new(5, 1'b0);
    for (int i = 0; i < 5; i++) exp_slot(i, 32'h200 - 32'(4*i), 4'h0, 4'hF, 32'h0, 32'h1000 + 32'(i));
    exp_q.push_back(cur);
    do_retire(1'b1);

    // Overlap: A load pending while B stores fill the other buffer
    do_req(1'b0, 4'hF, 32'h300, 32'h0, 1'b1);
    check("ovl_ready_after_A", 512'(lsu_req_ready_o), 512'(1));
    do_req(1'b1, 4'h3, 32'h400, 32'h44, 1'b0);
    do_req(1'b1, 4'hC, 32'h404, 32'h5500, 1'b1);
    check("ovl_ready_blocked", 512'(lsu_req_ready_o), 512'(0));
    do_resp(32'hA5A5A5A5, 1'b1);
    check("ovl_ready_blocked_A_complete", 512'(lsu_req_ready_o), 512'(0));
    exp_new(1, 1'b0); exp_slot(0, 32'h300, 4'hF, 4'h0, 32'hA5A5A5A5, 32'h0);
    exp_q.push_back(cur);
    wb_retire_i = 1'b1; wb_mem_i = 1'b1;
    check("ovl_ready_not_comb_on_retire", 512'(lsu_req_ready_o), 512'(0));
    tick();
    wb_retire_i = 1'b0; wb_mem_i = 1'b0;
    check("ovl_ready_after_retire", 512'(lsu_req_ready_o), 512'(1));
    check("ovl_done_B_pending", 512'(mem_done_o), 512'(0));
    do_resp(32'h1, 1'b0);
    do_resp(32'h2, 1'b1);
    exp_new(2, 1'b0);
    exp_slot(0, 32'h400, 4'h0, 4'h3, 32'h0, 32'h44);
    exp_slot(1, 32'h404, 4'h0, 4'hC, 32'h0, 32'h5500);
    exp_q.push_back(cur);
    do_retire(1'b1);

    // Overflow: 18 loads into a 16-slot group
    for (int i = 0; i < 18; i++) do_req(1'b0, 4'hF, 32'h1000 + 32'(4*i), 32'h0, i == 17);
    for (int i = 0; i < 17; i++) do_resp(32'hC0DE0000 + 32'(i), 1'b0);
    check("ovf_done_before_18th_resp", 512'(mem_done_o), 512'(0));
    do_resp(32'hC0DE0011, 1'b1);
    exp_new(16, 1'b1);
    for (int i = 0; i < 16; i++) exp_slot(i, 32'h1000 + 32'(4*i), 4'hF, 4'h0, 32'hC0DE0000 + 32'(i), 32'h0);
    exp_q.push_back(cur);
    do_retire(1'b1);

    // Non-memory retire while a completed group waits
    do_req(1'b0, 4'h5, 32'h700, 32'h0, 1'b1);
    do_resp(32'h77, 1'b1);
    exp_new(0, 1'b0);
    exp_q.push_back(cur);
    do_retire(1'b0);
    check("nonmem_group_untouched", 512'(mem_done_o), 512'(1));
    exp_new(1, 1'b0); exp_slot(0, 32'h700, 4'h5, 4'h0, 32'h77, 32'h0);
    exp_q.push_back(cur);
    do_retire(1'b1);

    // Reset while a group waits for its response
    do_req(1'b0, 4'hF, 32'h500, 32'h0, 1'b1);
    rst_n = 1'b0;
    tick();
    check("midrst_done",  512'(mem_done_o),       512'(0));
    check("midrst_valid", 512'(rvfi_mem_valid_o), 512'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready_after_release", 512'(lsu_req_ready_o), 512'(1));
    check("midrst_cnt", 512'(rvfi_mem_cnt_o), 512'(0));
    do_req(1'b0, 4'hF, 32'h600, 32'h0, 1'b1);
    do_resp(32'h12345678, 1'b1);
    exp_new(1, 1'b0); exp_slot(0, 32'h600, 4'hF, 4'h0, 32'h12345678, 32'h0);
    exp_q.push_back(cur);
    do_retire(1'b1);

    repeat (3) tick();
    check("pulse_count", 512'(n_pulses), 512'(8));
    check("scoreboard_drained", 512'(exp_q.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40x_rvfi_mem_tracker.md
Name: cv32e40x_rvfi_mem_tracker

Overview:
Sequencer that collects data-side OBI transactions per instruction and releases them to RVFI when the instruction retires from WB. It supports multi-op instructions (Zc push/pop, misaligned splits) by grouping requests until a last-op marker. It holds up to two instruction groups in a ping-pong buffer so EX can issue while WB waits. It tells the controller when the WB instruction's memory data is complete, which gates retirement.

Parameters:
NMEM, 16, maximum transactions recorded per instruction; excess is dropped and flagged.
NBUF, 2, number of instruction groups in flight; fixed at 2 in this revision.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lsu_req_valid_i  in  1  OBI data request accepted this cycle (req & gnt)
lsu_req_ready_o  out  1  tracker can accept another request
lsu_req_last_i  in  1  request is the final op of its instruction
lsu_req_we_i  in  1  write
lsu_req_be_i  in  4  byte enables
lsu_req_addr_i  in  32  address
lsu_req_wdata_i  in  32  write data
lsu_resp_valid_i  in  1  OBI response (in order)
lsu_resp_rdata_i  in  32  read data
lsu_resp_err_i  in  1  bus error
wb_mem_i  in  1  WB instruction is a memory instruction
wb_retire_i  in  1  WB instruction leaves the pipeline (retire or trap)
mem_done_o  out  1  oldest group is COMPLETE
rvfi_mem_valid_o  out  1  one-cycle pulse with the group contents
rvfi_mem_cnt_o  out  $clog2(NMEM+1)  number of valid slots
rvfi_mem_addr_o  out  NMEM*32  slot addresses; slot 0 in the LSBs
rvfi_mem_rmask_o  out  NMEM*4  read masks
rvfi_mem_wmask_o  out  NMEM*4  write masks
rvfi_mem_rdata_o  out  NMEM*32  read data
rvfi_mem_wdata_o  out  NMEM*32  write data
rvfi_mem_ovf_o  out  1  group exceeded NMEM

Behaviour:
- Reset: all outputs 0; both buffers EMPTY; fill, resp and retire pointers 0; lsu_req_ready_o = 1 once reset is released.
- Per-buffer FSM:
  - EMPTY -> FILLING on the first request.
  - FILLING -> WAIT_RESP when a request with last=1 arrives.
  - WAIT_RESP -> COMPLETE when the response count equals the request count.
  - COMPLETE -> EMPTY on wb_retire_i & wb_mem_i.
  - A single last=1 request moves EMPTY directly to WAIT_RESP.
- Request capture:
  - Slot = fill count. Store addr and wdata.
  - rmask = we ? 0 : be; wmask = we ? be : 0.
  - Fill count increments. When last=1, the fill pointer toggles.
- Overflow: at fill count == NMEM, the request is not stored and ovf is set sticky for that group. Its response is still counted.
- Responses: written to the buffer at the resp pointer, slot = resp count. rdata is stored only when rmask != 0. The resp pointer toggles after the group's final response.
- lsu_req_ready_o = 0 when the buffer at the fill pointer is not EMPTY or FILLING. A request while ready=0 is a protocol violation and is covered by an assertion.
- mem_done_o is registered: it rises the cycle after the final response. It is never asserted in the same cycle as that response.
- Retire with wb_mem_i=1:
  - The next cycle: rvfi_mem_valid_o=1 with the oldest group's contents, cnt, and ovf.
  - The buffer becomes EMPTY and the retire pointer toggles.
  - Slots >= cnt output 0.
- Retire with wb_mem_i=0: the next cycle, rvfi_mem_valid_o=1 with cnt=0 and all vectors 0.
- wb_retire_i & wb_mem_i & !mem_done_o is a protocol violation (assertion).
- Simultaneous retire of buffer A and a request into buffer B: both are honoured. A retire freeing the buffer at the fill pointer makes ready rise the next cycle, not combinationally.
- Reset mid-operation clears all groups. Pending responses after reset are the LSU's responsibility.

Optional Feature:
CV32E40X_RVFI_MEM_ERR_EN
- Defined: adds output rvfi_mem_err_o [1:0] (mem_err_t) and rvfi_mem_err_valid_o. The first resp_err in a group records MEM_ERR_PMP and its slot index. The group completes immediately on an error response; later responses of that group are discarded.
- Undefined: resp_err is ignored and those ports do not exist.

Test Plan:
- Single load: req addr=0x100, be=0xF, we=0, last=1; resp rdata=0xDEADBEEF; retire -> valid pulse, cnt=1, rmask=0xF, wmask=0, rdata slot0=0xDEADBEEF.
- Push of 5 words: 5 writes to 0x200..0x1F0, last on the 5th, 5 responses -> mem_done_o rises 1 cycle after the 5th response; retire gives cnt=5 with correct wdata order.
- Overlap: instr A (1 load) pending response while instr B issues 2 stores -> ready stays 1; a third group request sees ready=0 until A retires; outputs A then B.
- Overflow: NMEM=16, 18 requests -> cnt=16, ovf=1, done only after the 18th response.
- Non-memory retire: wb_mem_i=0 -> valid pulse with cnt=0 and both buffers untouched.
- Reset asserted during WAIT_RESP -> all outputs 0, ready=1 after release, next instruction tracked from slot 0.
